// File: rtl/apb_timer_slave.sv
// apb_timer_slave: zero-wait-state APB peripheral holding a prescaled 32-bit
// down-counter with auto-reload, a write-1-to-clear pending flag and a level
// interrupt. Prdata is driven only while this slave is selected for a read,
// so several slaves on the same bridge can have their read data OR-combined.
//
// Bus handshake: there is no ready signal. A write takes effect on the rising
// edge that ends the access phase (sel & Penable & Pwrite). Read data is
// combinational and valid in both setup and access phases (sel & !Pwrite).
module apb_timer_slave #(
   parameter int          SEL_INDEX  = 0,
   parameter logic [31:0] RESET_LOAD = 32'h0000_0000
) (
   input  logic        Hclk,
   input  logic        Hreset,
   input  logic [2:0]  Pselx,
   input  logic        Penable,
   input  logic        Pwrite,
   input  logic [31:0] Paddr,
   input  logic [31:0] Pwdata,
   output logic [31:0] Prdata,
   output logic        Irq
);

   localparam logic [7:0] ADDR_CTRL     = 8'h00;
   localparam logic [7:0] ADDR_LOAD     = 8'h04;
   localparam logic [7:0] ADDR_VALUE    = 8'h08;
   localparam logic [7:0] ADDR_STATUS   = 8'h0C;
   localparam logic [7:0] ADDR_PRESCALE = 8'h10;

   logic        sel;
   logic        wr;
   logic        wr_ctrl;
   logic        wr_load;
   logic        wr_status;
   logic        wr_prescale;

   logic        ctrl_en;
   logic        ctrl_auto;
   logic        ctrl_ie;
   logic [31:0] load_reg;
   logic [31:0] value_reg;
   logic        pend;
   logic [15:0] prescale_reg;
   logic [15:0] pcnt;

   logic        tick;
   logic        tick_eff;
   logic        expire;
   logic        dec;

   // Address bits above the decoded byte and the other slaves' selects.
   logic        unused_bits;
   assign unused_bits = ^{Paddr[31:8], Pselx};

   assign sel         = Pselx[SEL_INDEX];
   assign wr          = sel & Penable & Pwrite;
   assign wr_ctrl     = wr & (Paddr[7:0] == ADDR_CTRL);
   assign wr_load     = wr & (Paddr[7:0] == ADDR_LOAD);
   assign wr_status   = wr & (Paddr[7:0] == ADDR_STATUS);
   assign wr_prescale = wr & (Paddr[7:0] == ADDR_PRESCALE);

   // A CTRL write that turns the timer off suppresses any tick in the same cycle.
   assign tick     = ctrl_en & (pcnt == prescale_reg);
   assign tick_eff = tick & ~(wr_ctrl & ~Pwdata[0]);
   assign expire   = tick_eff & (value_reg == 32'd1);
   assign dec      = tick_eff & (value_reg > 32'd1);

   // Interrupt comes from flops only.
   assign Irq = pend & ctrl_ie;

   // Control bits; a CTRL write overrides the one-shot self-disable.
   always_ff @(posedge Hclk) begin
      if (Hreset) begin
         ctrl_en   <= 1'b0;
         ctrl_auto <= 1'b0;
         ctrl_ie   <= 1'b0;
      end else if (wr_ctrl) begin
         ctrl_en   <= Pwdata[0];
         ctrl_auto <= Pwdata[1];
         ctrl_ie   <= Pwdata[2];
      end else if (expire && !ctrl_auto) begin
         ctrl_en   <= 1'b0;
      end
   end

   // LOAD and PRESCALE configuration registers.
   always_ff @(posedge Hclk) begin
      if (Hreset) begin
         load_reg     <= RESET_LOAD;
         prescale_reg <= 16'h0;
      end else begin
         if (wr_load)     load_reg     <= Pwdata;
         if (wr_prescale) prescale_reg <= Pwdata[15:0];
      end
   end

   // Down-counter; a LOAD write wins over any tick action on VALUE.
   always_ff @(posedge Hclk) begin
      if (Hreset) begin
         value_reg <= RESET_LOAD;
      end else if (wr_load) begin
         value_reg <= Pwdata;
      end else if (expire) begin
         value_reg <= ctrl_auto ? load_reg : 32'h0;
      end else if (dec) begin
         value_reg <= value_reg - 32'd1;
      end
   end

   // Pending flag; expiry has priority over a write-1-to-clear.
   always_ff @(posedge Hclk) begin
      if (Hreset) begin
         pend <= 1'b0;
      end else if (expire) begin
         pend <= 1'b1;
      end else if (wr_status && Pwdata[0]) begin
         pend <= 1'b0;
      end
   end

   // Prescaler: wraps at PRESCALE, held at zero while disabled or on CTRL write.
   always_ff @(posedge Hclk) begin
      if (Hreset || !ctrl_en || wr_ctrl) begin
         pcnt <= 16'h0;
      end else if (tick) begin
         pcnt <= 16'h0;
      end else begin
         pcnt <= pcnt + 16'd1;
      end
   end

   // Read mux; zero when not selected for a read so outputs can be OR-ed.
   always_comb begin
      Prdata = 32'h0;
      if (sel && !Pwrite) begin
         case (Paddr[7:0])
            ADDR_CTRL:     Prdata = {29'h0, ctrl_ie, ctrl_auto, ctrl_en};
            ADDR_LOAD:     Prdata = load_reg;
            ADDR_VALUE:    Prdata = value_reg;
            ADDR_STATUS:   Prdata = {31'h0, pend};
            ADDR_PRESCALE: Prdata = {16'h0, prescale_reg};
            default:       Prdata = 32'h0;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_timer_slave.sv
// Bench for apb_timer_slave (SEL_INDEX=1, RESET_LOAD=0). Driver tasks push
// the expected {Irq, Prdata} into exp_q; a monitor pops and compares on the
// falling edge of every cycle the driver marks as a read sample.
module tb_apb_timer_slave;

   logic        Hclk;
   logic        Hreset;
   logic [2:0]  Pselx;
   logic        Penable;
   logic        Pwrite;
   logic [31:0] Paddr;
   logic [31:0] Pwdata;
   logic [31:0] Prdata;
   logic        Irq;

   logic        mon_valid;
   logic [32:0] exp_q[$];
   string       name_q[$];
   int          checks;
   int          errors;

   localparam logic [2:0] SEL = 3'b010;

   apb_timer_slave #(
      .SEL_INDEX  (1),
      .RESET_LOAD (32'h0000_0000)
   ) dut (
      .Hclk    (Hclk),
      .Hreset  (Hreset),
      .Pselx   (Pselx),
      .Penable (Penable),
      .Pwrite  (Pwrite),
      .Paddr   (Paddr),
      .Pwdata  (Pwdata),
      .Prdata  (Prdata),
      .Irq     (Irq)
   );

   // Clock and watchdog
   initial begin
      Hclk = 1'b0;
      forever #5 Hclk = ~Hclk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required $finish before it");
      $fatal(1, "watchdog");
   end

   // Driver tasks: each starts and ends 1 time unit after a rising edge.
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge Hclk);
         #1;
      end
   endtask

   task automatic apb_write(input logic [2:0] psel, input logic [7:0] addr,
                            input logic [31:0] data);
      Pselx   = psel;
      Paddr   = {24'h0, addr};
      Pwdata  = data;
      Pwrite  = 1'b1;
      Penable = 1'b0;
      @(posedge Hclk);
      #1;
      Penable = 1'b1;
      @(posedge Hclk);
      #1;
      Pselx   = 3'b000;
      Penable = 1'b0;
      Pwrite  = 1'b0;
   endtask

   // Full two-phase read, sampled in the access phase.
   task automatic apb_read(input string nm, input logic [7:0] addr,
                           input logic exp_irq, input logic [31:0] exp_data);
      exp_q.push_back({exp_irq, exp_data});
      name_q.push_back(nm);
      Pselx   = SEL;
      Paddr   = {24'h0, addr};
      Pwrite  = 1'b0;
      Penable = 1'b0;
      @(posedge Hclk);
      #1;
      Penable   = 1'b1;
      mon_valid = 1'b1;
      @(posedge Hclk);
      #1;
      mon_valid = 1'b0;
      Pselx     = 3'b000;
      Penable   = 1'b0;
   endtask

   // One-cycle setup-phase sample, for observing the counter every cycle.
   task automatic peek(input string nm, input logic [2:0] psel, input logic [7:0] addr,
                       input logic exp_irq, input logic [31:0] exp_data);
      exp_q.push_back({exp_irq, exp_data});
      name_q.push_back(nm);
      Pselx     = psel;
      Paddr     = {24'h0, addr};
      Pwrite    = 1'b0;
      Penable   = 1'b0;
      mon_valid = 1'b1;
      @(posedge Hclk);
      #1;
      mon_valid = 1'b0;
      Pselx     = 3'b000;
   endtask

   // Scoreboard monitor
   always @(negedge Hclk) begin
      logic [32:0] exp;
      string       nm;
      if (mon_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL monitor: sample with empty expected queue, got irq=%0b prdata=%h",
                     Irq, Prdata);
         end else begin
            exp = exp_q.pop_front();
            nm  = name_q.pop_front();
            if ({Irq, Prdata} !== exp) begin
               errors++;
               $display("FAIL %s: got irq=%0b prdata=%h, required irq=%0b prdata=%h",
                        nm, Irq, Prdata, exp[32], exp[31:0]);
            end
         end
      end
   end

   // Directed stimulus
   initial begin
      checks    = 0;
      errors    = 0;
      mon_valid = 1'b0;
      Hreset    = 1'b1;
      Pselx     = 3'b000;
      Penable   = 1'b0;
      Pwrite    = 1'b0;
      Paddr     = 32'h0;
      Pwdata    = 32'h0;

      // Reset and readback
      repeat (2) @(posedge Hclk);
      #1;
      Hreset = 1'b0;
      apb_read("rst_ctrl",     8'h00, 1'b0, 32'h0);
      apb_read("rst_load",     8'h04, 1'b0, 32'h0);
      apb_read("rst_value",    8'h08, 1'b0, 32'h0);
      apb_read("rst_status",   8'h0C, 1'b0, 32'h0);
      apb_read("rst_prescale", 8'h10, 1'b0, 32'h0);

      // One-shot, prescale 0: ticks every cycle starting one cycle after enable
      apb_write(SEL, 8'h10, 32'h0);
      apb_write(SEL, 8'h04, 32'd3);
      peek("unsel_zero", 3'b000, 8'h04, 1'b0, 32'h0);
      apb_write(SEL, 8'h00, 32'h5);
      peek("os_v3", SEL, 8'h08, 1'b0, 32'd3);
      peek("os_v2", SEL, 8'h08, 1'b0, 32'd2);
      peek("os_v1", SEL, 8'h08, 1'b0, 32'd1);
      peek("os_v0", SEL, 8'h08, 1'b1, 32'd0);
      apb_read("os_ctrl",   8'h00, 1'b1, 32'h4);
      apb_read("os_status", 8'h0C, 1'b1, 32'h1);
      apb_read("os_hold0",  8'h08, 1'b1, 32'h0);
      apb_write(SEL, 8'h0C, 32'h1);
      apb_read("os_clr", 8'h0C, 1'b0, 32'h0);

      // Auto-reload, prescale 2: value changes every 3 cycles
      apb_write(SEL, 8'h10, 32'd2);
      apb_write(SEL, 8'h04, 32'd2);
      apb_write(SEL, 8'h00, 32'h7);
      for (int k = 0; k < 12; k++) begin
         peek("ar_value", SEL, 8'h08, (k >= 6), (((k / 3) % 2) == 0) ? 32'd2 : 32'd1);
      end
      // Clear pending; next expiry is on the edge ending the 4th sample below
      apb_write(SEL, 8'h0C, 32'h1);
      for (int k = 0; k < 4; k++) begin
         peek("ar_cleared", SEL, 8'h0C, 1'b0, 32'h0);
      end
      peek("ar_repend", SEL, 8'h0C, 1'b1, 32'h1);

      // W1C on the expiry edge: set wins
      idle(3);
      apb_write(SEL, 8'h0C, 32'h1);
      peek("col_w1c", SEL, 8'h0C, 1'b1, 32'h1);
      peek("col_reload", SEL, 8'h08, 1'b1, 32'd2);
      // LOAD write on a tick edge: write wins
      idle(2);
      apb_write(SEL, 8'h04, 32'h10);
      peek("col_load", SEL, 8'h08, 1'b1, 32'h10);

      // Stop and clear
      apb_write(SEL, 8'h00, 32'h0);
      apb_write(SEL, 8'h0C, 32'h1);
      apb_read("stop_ctrl",   8'h00, 1'b0, 32'h0);
      apb_read("stop_status", 8'h0C, 1'b0, 32'h0);

      // Select and decode
      apb_write(3'b001, 8'h04, 32'h55);
      apb_read("sel_other", 8'h04, 1'b0, 32'h10);
      apb_write(3'b010, 8'h04, 32'h55);
      apb_read("sel_load",  8'h04, 1'b0, 32'h55);
      apb_read("sel_value", 8'h08, 1'b0, 32'h55);
      apb_write(SEL, 8'h08, 32'h99);
      apb_read("value_ro", 8'h08, 1'b0, 32'h55);
      apb_read("unmapped", 8'h20, 1'b0, 32'h0);
      apb_write(SEL, 8'h20, 32'hFFFF_FFFF);
      apb_read("unmapped_wr", 8'h00, 1'b0, 32'h0);
      // Setup phase only: no register change
      Pselx  = SEL;
      Paddr  = 32'h4;
      Pwdata = 32'hAA;
      Pwrite = 1'b1;
      idle(1);
      Pselx  = 3'b000;
      Pwrite = 1'b0;
      apb_read("setup_only", 8'h04, 1'b0, 32'h55);
      apb_write(SEL, 8'h00, 32'hFFFF_FFFA);
      apb_read("ctrl_mask", 8'h00, 1'b0, 32'h2);
      apb_write(SEL, 8'h10, 32'hABCD_1234);
      apb_read("pre_mask", 8'h10, 1'b0, 32'h1234);

      // Reset mid-count
      apb_write(SEL, 8'h10, 32'h0);
      apb_write(SEL, 8'h04, 32'd100);
      apb_write(SEL, 8'h00, 32'h1);
      peek("mid_v100", SEL, 8'h08, 1'b0, 32'd100);
      idle(41);
      peek("mid_v58", SEL, 8'h08, 1'b0, 32'd58);
      Hreset = 1'b1;
      peek("mid_v57", SEL, 8'h08, 1'b0, 32'd57);
      peek("mid_rst", SEL, 8'h08, 1'b0, 32'd0);
      Hreset = 1'b0;
      peek("mid_ctrl", SEL, 8'h00, 1'b0, 32'h0);
      idle(5);
      peek("mid_stopped", SEL, 8'h08, 1'b0, 32'd0);
      apb_read("mid_load", 8'h04, 1'b0, 32'h0);

      // Every expected entry must have been consumed
      idle(2);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: %0d entries left, required 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_timer_slave.md
Name: apb_timer_slave

Overview:
- APB slave peripheral downstream of the AHB-to-APB bridge.
- Consumes the bridge's Pselx/Penable/Pwrite/Paddr/Pwdata and returns Prdata, with zero wait states; the bridge has no Pready.
- Implements a prescaled 32-bit down-counter timer with a register file, auto-reload and an interrupt line.
- One instance attaches to one bit of the bridge's 3-bit Pselx.

Parameters:
- SEL_INDEX, 0, which Pselx bit (0..2) selects this slave.
- RESET_LOAD, 32'h0000_0000, reset value of the LOAD register.

Ports:
- Hclk  input  1  system clock; all flops update on the rising edge.
- Hreset  input  1  synchronous reset, active-high; sampled on the Hclk rising edge.
- Pselx  input  3  APB slave selects from the bridge; this slave responds to Pselx[SEL_INDEX].
- Penable  input  1  APB access phase.
- Pwrite  input  1  1 = write, 0 = read.
- Paddr  input  32  byte address; only Paddr[7:0] is decoded.
- Pwdata  input  32  write data.
- Prdata  output  32  read data to the bridge.
- Irq  output  1  timer interrupt, level.

Behaviour:
- sel = Pselx[SEL_INDEX].
- Write strobe wr = sel & Penable & Pwrite. Registers update on the Hclk edge ending the access phase. The setup phase has no effect.
- Prdata is combinational: register contents when sel & !Pwrite (both setup and access phase), else 32'h0, so slave outputs may be OR-combined.
- Unmapped offsets read 0. Writes to unmapped offsets are ignored.
- Register map (Paddr[7:0]):
  - 0x00 CTRL, RW: bit0 EN, bit1 AUTO (auto-reload), bit2 IE (interrupt enable). Bits [31:3] read 0.
  - 0x04 LOAD, RW, 32 bits. A write also copies Pwdata into VALUE in the same edge.
  - 0x08 VALUE, RO. Writes are ignored.
  - 0x0C STATUS: bit0 PEND. Write-1-to-clear; writing 0 has no effect.
  - 0x10 PRESCALE, RW, bits [15:0]. Bits [31:16] read 0.
- Prescaler:
  - 16-bit counter pcnt. Cleared when EN=0 and on any write to CTRL.
  - When EN=1: if pcnt == PRESCALE, tick = 1 and pcnt <= 0; else pcnt <= pcnt + 1.
  - A tick therefore occurs every PRESCALE+1 cycles.
- Counter action on tick:
  - VALUE > 1: VALUE <= VALUE - 1.
  - VALUE == 1 (expiry): PEND <= 1. If AUTO, VALUE <= LOAD. Else VALUE <= 0 and EN <= 0.
  - VALUE == 0: no action, no expiry.
- Irq = PEND & IE, derived from flops only, no combinational path from APB inputs.
- Simultaneous events:
  - STATUS W1C write and expiry in the same cycle: set wins, PEND = 1.
  - LOAD write and tick in the same cycle: the write wins, VALUE = Pwdata.
  - CTRL write setting EN=0 and tick in the same cycle: the write wins, no decrement.
  - Expiry clearing EN (AUTO=0) while CTRL is being written: the CTRL write wins.
- Reset (Hreset=1 at an edge, including mid-count or mid-transfer):
  - CTRL=0, LOAD=RESET_LOAD, VALUE=RESET_LOAD, PEND=0, PRESCALE=0, pcnt=0.
  - Irq=0. Prdata follows the register contents combinationally.
  - An in-flight APB access is discarded.

Test Plan:
- Reset/readback: assert Hreset 2 cycles; read 0x00, 0x04, 0x08, 0x0C, 0x10 -> all 0 (RESET_LOAD=0); Irq=0; Prdata=0 when Pselx=3'b000.
- One-shot: PRESCALE=0, LOAD=3, CTRL=3'b101 -> VALUE reads 2, 1, 0 on successive cycles after the enable write; PEND=1 and Irq=1 at the cycle VALUE hits 0; CTRL reads 3'b100; VALUE stays 0.
- Auto-reload with prescale: PRESCALE=2, LOAD=2, CTRL=3'b111 -> VALUE changes every 3 cycles: 2 -> 1 -> 2 (reload, PEND=1) -> 1 -> 2; write 1 to 0x0C -> PEND=0 until next expiry.
- Collision: arrange W1C of STATUS on the same edge as an expiry -> PEND reads 1. Write LOAD=0x10 on a tick edge -> VALUE reads 0x10.
- Select/decode: SEL_INDEX=1; write 0x55 to 0x04 with Pselx=3'b001 -> LOAD unchanged. Same write with Pselx=3'b010 -> LOAD=0x55. Read 0x20 -> 0. Setup phase with Penable=0, Pwrite=1 alone -> no register change.
- Reset mid-count: LOAD=100, running, assert Hreset at VALUE=57 -> next cycle VALUE=0, CTRL=0, Irq=0; counting stays stopped after Hreset deasserts.
